multi_unit: RTL and testbench
=============================

Name: multi_unit

Overview:
- Sequential radix-2 shift-add unsigned integer multiplier.
- Serves as the MultiUnit behind the IEEE754 multiply stage. That stage drives its mantissa operands and trigger into this block, and consumes the selected product window plus a sticky bit for rounding.
- One multiplication in flight at a time, fixed latency, single-cycle result strobe.

Parameters:
- WIDTH, 32, operand width in bits; the internal product is 2*WIDTH bits.
- OUT_LSB, 16, lowest product bit presented on data_out.
  - Legal range is 0..WIDTH.
  - data_out = product[OUT_LSB+WIDTH-1 : OUT_LSB].

Ports:
- sys_clk  input  1  system clock; all logic on its rising edge.
- sys_rst  input  1  synchronous, active-high reset.
- data1_in  input  WIDTH  multiplicand, unsigned; sampled only when a trigger is accepted.
- data2_in  input  WIDTH  multiplier, unsigned; sampled only when a trigger is accepted.
- trig  input  1  start request; accepted only in IDLE.
- data_out  output  WIDTH  product window; registered; holds its value until the next completion.
- sticky_out  output  1  OR of product[OUT_LSB-1:0]; constant 0 when OUT_LSB=0; registered with data_out.
- vld  output  1  one-cycle pulse marking data_out/sticky_out as new.
- busy  output  1  high while in CALC.

Behaviour:
- Reset (sys_rst high at a rising edge):
  - state=IDLE, data_out=0, sticky_out=0, vld=0, busy=0.
  - Accumulator, operand registers and counter are cleared.
  - Reset mid-operation abandons the calculation; no vld is produced for it.
- State machine has two states, IDLE and CALC.
- IDLE:
  - trig high at edge E0: latch mcand=data1_in zero-extended to 2*WIDTH, mplier=data2_in, acc=0, count=0; go to CALC; busy=1 from E0.
  - trig low: remain in IDLE; vld cleared.
- CALC, one iteration per edge:
  - If mplier[0], acc <= acc + mcand (2*WIDTH-bit add; cannot overflow).
  - Then mcand <<= 1, mplier >>= 1, count++.
  - No early termination; every operation takes exactly WIDTH iterations (edges E1..E_WIDTH).
- Completion at edge E_WIDTH:
  - data_out <= final product window, sticky_out <= OR of the low OUT_LSB bits of the final product, vld <= 1.
  - State returns to IDLE and busy <= 0.
  - The final-iteration add result feeds data_out directly, so there is no extra cycle.
- Latency: vld is high in the cycle following E_WIDTH, i.e. WIDTH cycles after the trigger-sampling edge (32 for the default).
- vld is cleared at the next edge unless a new completion occurs.
- Back-to-back operation:
  - trig high during the vld cycle is accepted (state is already IDLE).
  - Peak throughput is one result per WIDTH+1 cycles.
- trig while busy is ignored: not queued, and the operands in flight are unaffected.
- Input stability: data*_in need be valid only in the accepting cycle.
- Product bits above OUT_LSB+WIDTH-1 are discarded. The upstream stage is responsible for placing its operands so that nothing significant is lost.
- Counter width is clog2(WIDTH+1).

Decomposition:
- Shared package (alu_pkg):
  - State enum {IDLE, CALC}.
  - Default WIDTH/OUT_LSB constants.
  - Mantissa width constant 24, shared with the floating-point stages.
- Sub-module: none required.
  - The datapath is one adder plus shift registers inline with the FSM.
  - An optional mul_step cell (acc/mcand/mplier one-iteration update) is permitted but not needed.

Test Plan:
- Default params, data1_in=0x00800000, data2_in=0x00800000, trig pulse -> vld exactly 32 cycles after the accepting edge; data_out=0x40000000, sticky_out=0.
- data1_in=data2_in=0x00FFFFFF (product 0xFFFFFE000001) -> data_out=0xFFFFFE00, sticky_out=1.
- data1_in=data2_in=0xFFFFFFFF (product 0xFFFFFFFE00000001) -> data_out=0xFFFE0000, sticky_out=1 (upper bits truncated).
- data1_in=0, data2_in=0x12345678 -> data_out=0, sticky_out=0, vld still at 32 cycles.
- Start 3 x 5, then pulse trig with 7 x 7 at cycle 10 -> the second trigger is ignored; the result is for 3 x 5.
  - Check with OUT_LSB=0 instance: data_out=15.
  - Then trig held high during the vld cycle -> the next operation starts and its vld arrives 32 cycles later.
- Assert sys_rst at cycle 16 of an operation -> no vld; all outputs 0 on the next cycle; a new trig afterwards completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the arithmetic units behind the floating-point pipeline.
package alu_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_OUT_LSB = 16;
  localparam int MANT_WIDTH  = 24;

endpackage

// File: rtl/multi_unit.sv
// Sequential radix-2 shift-add unsigned multiplier with a selectable product window
// and a sticky bit covering everything below the window.
module multi_unit
  import alu_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int OUT_LSB = DEF_OUT_LSB
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic [WIDTH-1:0] data1_in,
  input  logic [WIDTH-1:0] data2_in,
  input  logic             trig,
  output logic [WIDTH-1:0] data_out,
  output logic             sticky_out,
  output logic             vld,
  output logic             busy
);

  localparam int PW    = 2 * WIDTH;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             sticky_q, sticky_d;
  logic             vld_q, vld_d;

  logic [PW-1:0]    acc_sum;
  logic             sticky_sum;

  // The final iteration's sum feeds the output window directly, saving a cycle.
  assign acc_sum = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  generate
    if (OUT_LSB == 0) begin : g_no_sticky
      assign sticky_sum = 1'b0;
    end else begin : g_sticky
      assign sticky_sum = |acc_sum[OUT_LSB-1:0];
    end
  endgenerate

  always_comb begin
    state_d    = state_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    acc_d      = acc_q;
    count_d    = count_q;
    data_out_d = data_out_q;
    sticky_d   = sticky_q;
    vld_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (trig) begin
          mcand_d  = {{WIDTH{1'b0}}, data1_in};
          mplier_d = data2_in;
          acc_d    = '0;
          count_d  = '0;
          state_d  = CALC;
        end
      end
      CALC: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + CNT_W'(1);
        if (count_q == LAST) begin
          data_out_d = acc_sum[OUT_LSB+WIDTH-1:OUT_LSB];
          sticky_d   = sticky_sum;
          vld_d      = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= IDLE;
      mcand_q    <= '0;
      mplier_q   <= '0;
      acc_q      <= '0;
      count_q    <= '0;
      data_out_q <= '0;
      sticky_q   <= 1'b0;
      vld_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      acc_q      <= acc_d;
      count_q    <= count_d;
      data_out_q <= data_out_d;
      sticky_q   <= sticky_d;
      vld_q      <= vld_d;
    end
  end

  assign data_out   = data_out_q;
  assign sticky_out = sticky_q;
  assign vld        = vld_q;
  assign busy       = (state_q == CALC);

endmodule

// File: tb/tb_multi_unit.sv
// Directed bench: a default-window instance and an OUT_LSB=0 instance share stimulus.
module tb_multi_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] d1, d2;
  logic        trig;

  logic [31:0] dout, dout0;
  logic        sticky, sticky0, vld, vld0, busy, busy0;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int lat;
  int vld_seen;

  always #5 clk = ~clk;

  multi_unit #(.WIDTH(32), .OUT_LSB(16)) dut (
    .sys_clk(clk), .sys_rst(rst), .data1_in(d1), .data2_in(d2), .trig(trig),
    .data_out(dout), .sticky_out(sticky), .vld(vld), .busy(busy)
  );

  multi_unit #(.WIDTH(32), .OUT_LSB(0)) dut0 (
    .sys_clk(clk), .sys_rst(rst), .data1_in(d1), .data2_in(d2), .trig(trig),
    .data_out(dout0), .sticky_out(sticky0), .vld(vld0), .busy(busy0)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Present operands with trig for one edge (the accepting edge E0), then scramble inputs.
  task automatic start(input logic [31:0] a, input logic [31:0] b);
    d1 = a;
    d2 = b;
    trig = 1'b1;
    @(posedge clk);
    #1;
    trig = 1'b0;
    d1 = $urandom;
    d2 = $urandom;
    cyc = 0;
  endtask

  // Steps until vld rises (bounded); returns cycles since the accepting edge.
  task automatic wait_done(output int latency);
    latency = -1;
    for (int i = 0; i < 45; i++) begin
      step();
      if (vld) begin
        latency = cyc;
        break;
      end
    end
  endtask

  initial begin
    rst  = 1'b1;
    trig = 1'b0;
    d1   = '0;
    d2   = '0;
    repeat (3) step();
    rst = 1'b0;
    step();
    check("reset_dout", dout, 0);
    check("reset_sticky", sticky, 0);
    check("reset_vld", vld, 0);
    check("reset_busy", busy, 0);
    $display("reset released: data_out=%h sticky=%b vld=%b busy=%b", dout, sticky, vld, busy);

    // 2^23 * 2^23 = 2^46 -> window bit 30
    start(32'h0080_0000, 32'h0080_0000);
    check("t1_busy", busy, 1);
    wait_done(lat);
    check("t1_latency", lat, 32);
    check("t1_dout", dout, 64'h4000_0000);
    check("t1_sticky", sticky, 0);
    check("t1_dout0", dout0, 0);
    $display("0x00800000*0x00800000: lat=%0d data_out=%h sticky=%b", lat, dout, sticky);
    step();
    check("t1_vld_drop", vld, 0);
    check("t1_busy_idle", busy, 0);

    start(32'h00FF_FFFF, 32'h00FF_FFFF);
    wait_done(lat);
    check("t2_latency", lat, 32);
    check("t2_dout", dout, 64'hFFFF_FE00);
    check("t2_sticky", sticky, 1);
    check("t2_dout0", dout0, 64'hFE00_0001);
    $display("0x00FFFFFF^2: lat=%0d data_out=%h sticky=%b", lat, dout, sticky);
    step();

    start(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(lat);
    check("t3_latency", lat, 32);
    check("t3_dout", dout, 64'hFFFE_0000);
    check("t3_sticky", sticky, 1);
    check("t3_dout0", dout0, 64'h0000_0001);
    $display("0xFFFFFFFF^2: lat=%0d data_out=%h sticky=%b", lat, dout, sticky);
    step();

    start(32'h0000_0000, 32'h1234_5678);
    wait_done(lat);
    check("t4_latency", lat, 32);
    check("t4_dout", dout, 0);
    check("t4_sticky", sticky, 0);
    $display("0*0x12345678: lat=%0d data_out=%h sticky=%b", lat, dout, sticky);
    step();

    // 3 x 5 with an ignored 7 x 7 trigger at cycle 10
    start(32'd3, 32'd5);
    repeat (9) step();
    d1 = 32'd7;
    d2 = 32'd7;
    trig = 1'b1;
    step();
    trig = 1'b0;
    check("t5_busy_mid", busy0, 1);
    wait_done(lat);
    check("t5_latency", lat, 32);
    check("t5_dout0", dout0, 15);
    check("t5_sticky0", sticky0, 0);
    check("t5_dout", dout, 0);
    check("t5_sticky", sticky, 1);
    $display("3*5 with ignored trig: lat=%0d data_out(lsb0)=%0d", lat, dout0);

    // trig held during the vld cycle starts the next operation immediately
    start(32'd7, 32'd7);
    check("t6_vld_drop", vld0, 0);
    check("t6_busy", busy0, 1);
    wait_done(lat);
    check("t6_latency", lat, 32);
    check("t6_dout0", dout0, 49);
    $display("7*7 back-to-back: lat=%0d data_out(lsb0)=%0d", lat, dout0);
    step();

    // reset at cycle 16 abandons the operation
    start(32'h0001_0000, 32'h0001_0000);
    repeat (15) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t7_dout", dout, 0);
    check("t7_sticky", sticky, 0);
    check("t7_vld", vld, 0);
    check("t7_busy", busy, 0);
    check("t7_dout0", dout0, 0);
    vld_seen = 0;
    repeat (24) begin
      step();
      if (vld || vld0) vld_seen++;
    end
    check("t7_no_vld", vld_seen, 0);
    $display("reset mid-op: data_out=%h busy=%b vld pulses after=%0d", dout, busy, vld_seen);

    start(32'h0000_1234, 32'h0000_0100);
    wait_done(lat);
    check("t8_latency", lat, 32);
    check("t8_dout", dout, 64'h0000_0012);
    check("t8_sticky", sticky, 1);
    check("t8_dout0", dout0, 64'h0012_3400);
    $display("0x1234*0x100 after reset: lat=%0d data_out=%h sticky=%b", lat, dout, sticky);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
